// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect N_BTN push-buttons into level, press and release outputs.
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat press train.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [N_BTN-1:0] s1, s2, lvl, lvl_next, rise, fall, press_next;
  logic [CW-1:0]    cnt      [N_BTN];
  logic [CW-1:0]    cnt_next [N_BTN];

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      lvl_next[i] = lvl[i];
      cnt_next[i] = '0;
      if (s2[i] != lvl[i]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end else begin
        cnt_next[i] = '0;
      end
    end
  end

  // Edges are taken from the next level so the pulse lands in the same cycle as the level change.
  assign rise = lvl_next & ~lvl;
  assign fall = ~lvl_next & lvl;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_e;

  rstate_e          state      [N_BTN];
  rstate_e          state_next [N_BTN];
  logic [RW-1:0]    rpt        [N_BTN];
  logic [RW-1:0]    rpt_next   [N_BTN];
  logic [N_BTN-1:0] rpt_pulse;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (!rst_n) begin
        state[i] <= IDLE;
        rpt[i]   <= '0;
      end else begin
        state[i] <= state_next[i];
        rpt[i]   <= rpt_next[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_next[i] = state[i];
      rpt_next[i]   = rpt[i];
      rpt_pulse[i]  = 1'b0;
      case (state[i])
        IDLE: begin
          if (rise[i]) begin
            state_next[i] = DELAY;
            rpt_next[i]   = '0;
          end else begin
            rpt_next[i]   = '0;
          end
        end
        DELAY, REPEAT: begin
          if (fall[i]) begin
            state_next[i] = IDLE;
            rpt_next[i]   = '0;
          end else if (rpt[i] == ((state[i] == DELAY) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1))) begin
            state_next[i] = REPEAT;
            rpt_next[i]   = '0;
            rpt_pulse[i]  = 1'b1;
          end else begin
            rpt_next[i]   = rpt[i] + RW'(1);
          end
        end
        default: begin
          state_next[i] = IDLE;
          rpt_next[i]   = '0;
        end
      endcase
    end
  end

  assign press_next = rise | rpt_pulse;
`else
  assign press_next = rise;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      lvl         <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      lvl         <= lvl_next;
      btn_press   <= press_next;
      btn_release <= fall;
      any_press   <= |press_next;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign btn_level = lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded random + directed bench for button_conditioner against an edge-count reference model.
module tb_button_conditioner;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 32;
  localparam int RR = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         any_press;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the input seen by the debouncer has disagreed with
  // it for D edges since it last agreed; presses repeat by elapsed hold time.
  initial begin : model
    int   e;
    int   last_agree [N];
    int   age [N];
    bit   p1 [N];
    bit   p2 [N];
    bit   lv [N];
    bit   v, old;
    logic [N-1:0] lvl_v, prs_v, rel_v;
    e = 0;
    for (int i = 0; i < N; i++) begin
      last_agree[i] = 0; age[i] = 0; p1[i] = 0; p2[i] = 0; lv[i] = 0;
    end
    forever begin
      @(posedge clk);
      e++;
      lvl_v = '0; prs_v = '0; rel_v = '0;
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          p1[i] = 0; p2[i] = 0; lv[i] = 0; last_agree[i] = e; age[i] = 0;
        end else begin
          v = p2[i];
          p2[i] = p1[i];
          p1[i] = btn_in[i];
          old = lv[i];
          if (v == lv[i]) begin
            last_agree[i] = e;
          end else if (e - last_agree[i] >= D) begin
            lv[i] = v;
            last_agree[i] = e;
          end
          if (lv[i] && !old) begin
            prs_v[i] = 1'b1;
            age[i] = 0;
          end else if (lv[i]) begin
            age[i]++;
`ifdef BTN_AUTOREPEAT_EN
            if (age[i] >= RD && ((age[i] - RD) % RR) == 0) prs_v[i] = 1'b1;
`endif
          end
          if (!lv[i] && old) rel_v[i] = 1'b1;
          lvl_v[i] = lv[i];
        end
      end
      exp_q.push_back({lvl_v, prs_v, rel_v, |prs_v});
    end
  end

  // Monitor: compare every registered output bundle against the next scoreboard entry.
  initial begin : monitor
    logic [15:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {btn_level, btn_press, btn_release, any_press};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL outputs t=%0t: got lvl=%b prs=%b rel=%b any=%b required lvl=%b prs=%b rel=%b any=%b",
                   $time, got_v[15:11], got_v[10:6], got_v[5:1], got_v[0],
                   exp_v[15:11], exp_v[10:6], exp_v[5:1], exp_v[0]);
        end
      end
    end
  end

  task automatic hold(input logic [N-1:0] val, input int cycles);
    btn_in = val;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin : driver
    rst_n = 1'b0; btn_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(5'b00000, 100);
    hold(5'b00001, 40);
    hold(5'b00000, 20);
    // Glitch train on channel 2 never reaches D consecutive samples.
    hold(5'b00100, 3);
    hold(5'b00000, 1);
    hold(5'b00100, 3);
    hold(5'b00000, 20);
    hold(5'b10010, 15);
    hold(5'b00000, 15);
    hold(5'b01000, 70);
    hold(5'b00000, 40);
    hold(5'b00010, 26);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(5'b00010, 30);
    hold(5'b00000, 20);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) btn_in[i] = ~btn_in[i];
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    hold(5'b11111, 60);
    hold(5'b00000, 20);
    @(negedge clk);
    total++;
    if (exp_q.size() > 1) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required at most 1", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
